// File: rtl/wordcell_array_ctrl.sv
// -----------------------------------------------------------------------------
// wordcell_array_ctrl
//
// Purpose:
//   Sequential access controller for an array of DATA_W-bit word cells.
//   Takes one read/write request at a time over a valid/ready handshake.
//   Each in-range access is sequenced as SETUP -> STROBE -> HOLD -> RESP.
//   cell_rw and cell_in_bus are settled one cycle before the word select rises.
//   They are held one cycle after it falls.
//   Out-of-range addresses skip the array and return an error response.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   req_valid     request present
//   req_ready     controller can accept a request (IDLE only)
//   req_write     1 = write, 0 = read
//   req_addr      target word index
//   req_wdata     write data
//   resp_valid    one-cycle completion pulse
//   resp_rdata    read data, valid with resp_valid on reads
//   resp_err      address out of range, valid with resp_valid
//   cell_rw       array rw line (1 = write, 0 = read)
//   cell_sel      one-hot word select
//   cell_in_bus   shared array write bus
//   cell_out_bus  shared array read bus from the selected word
// -----------------------------------------------------------------------------
module wordcell_array_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              cell_rw,
    output logic [DEPTH-1:0]  cell_sel,
    output logic [DATA_W-1:0] cell_in_bus,
    input  logic [DATA_W-1:0] cell_out_bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t              r_state;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_sample;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_err;
    logic                r_cell_rw;
    logic [DEPTH-1:0]    r_cell_sel;
    logic [DATA_W-1:0]   r_cell_in_bus;

    logic                w_accept;
    logic                w_in_range;
    logic [DEPTH-1:0]    w_sel_decode;

    assign w_accept   = req_valid && r_req_ready;
    assign w_in_range = ({1'b0, req_addr} < DEPTH_L);

    // Decode of the held address; only ever loaded into cell_sel for in-range
    // requests, so indices >= DEPTH never need a bit.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_decode = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_sel_decode[i] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_sample      <= '0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_err    <= 1'b0;
            r_cell_rw     <= 1'b0;
            r_cell_sel    <= '0;
            r_cell_in_bus <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_req_ready <= 1'b0;
                        if (w_in_range) begin
                            // Bus and rw settle here, a full cycle before the select.
                            r_state       <= ST_SETUP;
                            r_cell_rw     <= req_write;
                            r_cell_in_bus <= req_write ? req_wdata : '0;
                        end else begin
                            // Array is never touched: straight to the error response.
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state    <= ST_STROBE;
                    r_cell_sel <= w_sel_decode;
                end
                ST_STROBE: begin
                    // Select is still high at this edge, so the read bus is valid.
                    r_state    <= ST_HOLD;
                    r_cell_sel <= '0;
                    if (!r_write) begin
                        r_sample <= cell_out_bus;
                    end
                end
                ST_HOLD: begin
                    r_state       <= ST_RESP;
                    r_resp_valid  <= 1'b1;
                    r_resp_err    <= 1'b0;
                    r_resp_rdata  <= r_write ? '0 : r_sample;
                    r_cell_rw     <= 1'b0;
                    r_cell_in_bus <= '0;
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_req_ready   <= 1'b1;
                    r_resp_valid  <= 1'b0;
                    r_cell_rw     <= 1'b0;
                    r_cell_sel    <= '0;
                    r_cell_in_bus <= '0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign cell_rw     = r_cell_rw;
    assign cell_sel    = r_cell_sel;
    assign cell_in_bus = r_cell_in_bus;

endmodule

// File: tb/tb_wordcell_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wordcell_array_ctrl
//
// Purpose:
//   Drives wordcell_array_ctrl with DEPTH=6 so that addresses 6 and 7 are out of range.
//   A behavioural word-cell array is attached to the cell_* pins.
//   The stimulus side pushes each accepted request's expected response onto a queue.
//   A monitor pops the queue on every resp_valid and checks the response.
//   The reference memory is a plain array.
//   A write commits to it when the write's response is observed.
//   A request dropped by reset therefore never reaches it.
// -----------------------------------------------------------------------------
module tb_wordcell_array_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 6;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              cell_rw;
    logic [DEPTH-1:0]  cell_sel;
    logic [DATA_W-1:0] cell_in_bus;
    logic [DATA_W-1:0] cell_out_bus;

    wordcell_array_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .cell_rw     (cell_rw),
        .cell_sel    (cell_sel),
        .cell_in_bus (cell_in_bus),
        .cell_out_bus(cell_out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic              write;
        int                addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
        int                exp_lat;
        int                acc_cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] ref_mem[DEPTH];
    logic [DATA_W-1:0] arr[DEPTH];
    logic              cur_oor = 1'b0;
    logic              prev_rw = 1'b0;
    logic [DATA_W-1:0] prev_in = '0;

    int n_vec     = 0;
    int n_miscmp  = 0;
    int n_checks  = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            arr[i]     = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural word-cell array: captures on a rising edge while selected for
    // write, and presents the selected word on the read bus.
    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (cell_sel[i] && cell_rw) arr[i] = cell_in_bus;
        end
    end

    always_comb begin
        cell_out_bus = 8'hEE;
        for (int i = 0; i < DEPTH; i++) begin
            if (cell_sel[i]) cell_out_bus = arr[i];
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.exp_rdata);
                check("resp_err", resp_err, e.exp_err);
                check("resp_latency", cyc - e.acc_cyc + 1, e.exp_lat);
                if (e.write && !e.exp_err) ref_mem[e.addr] = e.wdata;
            end
        end
    end

    // Sequencing invariants, sampled every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("sel_onehot0", $onehot0(cell_sel), 32'd1);
            if (|cell_sel) begin
                check("rw_stable_under_sel", cell_rw, prev_rw);
                check("bus_stable_under_sel", cell_in_bus, prev_in);
            end
            if (cur_oor) begin
                check("oor_no_sel", cell_sel, 32'd0);
                check("oor_no_rw", cell_rw, 32'd0);
            end
        end
        prev_rw = cell_rw;
        prev_in = cell_in_bus;
    end

    // Called at a falling edge: applies inputs, records an accept if one will
    // happen at the coming rising edge, then waits for the next falling edge.
    task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output logic acc);
        exp_t e;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        acc = v && req_ready && !rst;
        if (acc) begin
            e.write     = w;
            e.addr      = int'(a);
            e.wdata     = d;
            e.exp_err   = (int'(a) >= DEPTH);
            e.exp_rdata = (!w && int'(a) < DEPTH) ? ref_mem[int'(a)] : '0;
            e.exp_lat   = (int'(a) < DEPTH) ? 4 : 1;
            e.acc_cyc   = cyc + 1;
            sb.push_back(e);
            cur_oor = e.exp_err;
            n_vec++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        logic dummy;
        drive(1'b0, 1'b0, '0, '0, dummy);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            idle();
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic acc = 1'b0;
        int   n = 0;
        while (!acc && n < 10) begin
            drive(1'b1, w, a, d, acc);
            n++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        drain(10);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 32'd1);
        check("rst_resp_valid", resp_valid, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", resp_err, 32'd0);
        check("rst_cell_rw", cell_rw, 32'd0);
        check("rst_cell_sel", cell_sel, 32'd0);
        check("rst_cell_in_bus", cell_in_bus, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x55 to addr 3, following the strobe sequence cycle by cycle.
        drive(1'b1, 1'b1, 3'd3, 8'h55, acc);
        check("w55_accept", acc, 32'd1);
        check("setup_sel", cell_sel, 32'd0);
        check("setup_rw", cell_rw, 32'd1);
        check("setup_bus", cell_in_bus, 32'h55);
        check("setup_ready", req_ready, 32'd0);
        idle();
        check("strobe_sel", cell_sel, 32'b001000);
        check("strobe_rw", cell_rw, 32'd1);
        check("strobe_bus", cell_in_bus, 32'h55);
        idle();
        check("hold_sel", cell_sel, 32'd0);
        check("hold_rw", cell_rw, 32'd1);
        check("hold_bus", cell_in_bus, 32'h55);
        idle();
        check("resp_pulse", resp_valid, 32'd1);
        check("resp_rw", cell_rw, 32'd0);
        check("resp_bus", cell_in_bus, 32'd0);
        idle();
        check("after_resp_valid", resp_valid, 32'd0);
        check("after_resp_ready", req_ready, 32'd1);
        do_req(1'b0, 3'd3, 8'h00);

        // Overwrite and address boundaries 0 and DEPTH-1.
        do_req(1'b1, 3'd3, 8'hCC);
        do_req(1'b1, 3'(DEPTH - 1), 8'h33);
        do_req(1'b0, 3'd3, 8'h00);
        do_req(1'b0, 3'(DEPTH - 1), 8'h00);
        do_req(1'b1, 3'd0, 8'h5A);
        do_req(1'b0, 3'd0, 8'h00);

        // Out of range: one-cycle error response, array untouched.
        drive(1'b1, 1'b0, 3'd6, 8'h00, acc);
        check("oor_accept", acc, 32'd1);
        check("oor_resp_valid", resp_valid, 32'd1);
        check("oor_resp_err", resp_err, 32'd1);
        check("oor_resp_rdata", resp_rdata, 32'd0);
        check("oor_sel", cell_sel, 32'd0);
        idle();
        check("oor_ready_back", req_ready, 32'd1);
        do_req(1'b1, 3'd7, 8'hF0);

        // Reset in the middle of a write strobe to addr 2.
        do_req(1'b1, 3'd2, 8'h12);
        drive(1'b1, 1'b1, 3'd2, 8'hA7, acc);
        idle();
        check("pre_rst_strobe_sel", cell_sel, 32'b000100);
        rst = 1'b1;
        #1;
        check("midrst_sel", cell_sel, 32'd0);
        check("midrst_rw", cell_rw, 32'd0);
        check("midrst_bus", cell_in_bus, 32'd0);
        check("midrst_ready", req_ready, 32'd1);
        sb.delete();
        cur_oor = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_resp", resp_valid, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 32'd1);
        do_req(1'b0, 3'd2, 8'h00);

        // Randomized requests with random idle gaps.
        repeat (40) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 2)) idle();
        end

        // Back-pressure: req_valid held high with changing fields every cycle.
        repeat (80) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), acc);
        end
        req_valid = 1'b0;
        drain(20);
        repeat (3) idle();
        check("final_queue_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
